// File: rtl/seq_universal_shifter_if.sv
// Bus interface for the sequential universal shifter: control, data and status.
interface seq_universal_shifter_if #(
    parameter int unsigned N  = 8,
    parameter int unsigned AW = 4
);
    logic          en;
    logic          start;
    logic          clr;
    logic          dir;
    logic [1:0]    mode;
    logic          sin;
    logic [AW-1:0] amt;
    logic [N-1:0]  in;
    logic [N-1:0]  out;
    logic          sout;
    logic          busy;
    logic          done;

    // Requester side: issues operations, observes results.
    modport master (
        output en, start, clr, dir, mode, sin, amt, in,
        input  out, sout, busy, done
    );

    // Shifter side.
    modport slave (
        input  en, start, clr, dir, mode, sin, amt, in,
        output out, sout, busy, done
    );
endinterface

// File: rtl/seq_universal_shifter.sv
// Multi-cycle universal shifter: loads a word, then shifts one bit per enabled
// clock in logical, arithmetic, rotate or serial-fill mode, either direction.
module seq_universal_shifter #(
    parameter int unsigned N  = 8,
    parameter int unsigned AW = 4
) (
    input  logic                    clk,
    input  logic                    res,
    seq_universal_shifter_if.slave  bus
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        MODE_LOGIC = 2'b00,
        MODE_ARITH = 2'b01,
        MODE_ROT   = 2'b10,
        MODE_FILL  = 2'b11
    } mode_e;

    state_e        state_q, state_d;
    mode_e         mode_q,  mode_d;
    logic          dir_q,   dir_d;
    logic [AW-1:0] cnt_q,   cnt_d;
    logic [N-1:0]  out_q,   out_d;
    logic          sout_q,  sout_d;
    logic          done_q,  done_d;
    logic          fill;

    // Fill bit entering the vacated end, chosen by latched direction and mode.
    always_comb begin
        fill = 1'b0;
        case (mode_q)
            MODE_LOGIC: fill = 1'b0;
            MODE_ARITH: fill = dir_q ? out_q[N-1] : 1'b0;
            MODE_ROT:   fill = dir_q ? out_q[0] : out_q[N-1];
            MODE_FILL:  fill = bus.sin;
            default:    fill = 1'b0;
        endcase
    end

    // Next-state and datapath: start acceptance, shift steps, stall and abort.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        sout_d  = sout_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // clr on the same edge suppresses the start
                if (bus.start && !bus.clr) begin
                    out_d  = bus.in;
                    sout_d = 1'b0;
                    cnt_d  = bus.amt;
                    dir_d  = bus.dir;
                    mode_d = mode_e'(bus.mode);
                    if (bus.amt == AW'(0)) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                if (bus.clr) begin
                    state_d = ST_IDLE;
                    cnt_d   = AW'(0);
                end else if (bus.en) begin
                    if (dir_q) begin
                        out_d  = {fill, out_q[N-1:1]};
                        sout_d = out_q[0];
                    end else begin
                        out_d  = {out_q[N-2:0], fill};
                        sout_d = out_q[N-1];
                    end
                    cnt_d = cnt_q - AW'(1);
                    if (cnt_q == AW'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_LOGIC;
            dir_q   <= 1'b0;
            cnt_q   <= AW'(0);
            out_q   <= N'(0);
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.sout = sout_q;
    assign bus.busy = (state_q == ST_SHIFT);
    assign bus.done = done_q;

endmodule

// File: tb/tb_seq_universal_shifter.sv
// Directed self-checking bench for seq_universal_shifter (N=8, AW=4).
module tb_seq_universal_shifter;

    localparam int unsigned N  = 8;
    localparam int unsigned AW = 4;

    logic clk;
    logic res;
    int   compared;
    int   mismatched;

    seq_universal_shifter_if #(.N(N), .AW(AW)) bus ();

    seq_universal_shifter #(.N(N), .AW(AW)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; return at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [7:0] din, input logic d, input logic [1:0] m,
                         input logic [3:0] a);
        bus.in    = din;
        bus.dir   = d;
        bus.mode  = m;
        bus.amt   = a;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        res        = 1'b0;
        bus.en     = 1'b1;
        bus.start  = 1'b0;
        bus.clr    = 1'b0;
        bus.dir    = 1'b0;
        bus.mode   = 2'b00;
        bus.sin    = 1'b0;
        bus.amt    = 4'd0;
        bus.in     = 8'h00;

        @(negedge clk);
        check("rst_out",  32'(bus.out),  32'h00);
        check("rst_sout", 32'(bus.sout), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        res = 1'b1;
        step();

        // LSL 10110011 by 3
        issue(8'b1011_0011, 1'b0, 2'b00, 4'd3);
        check("lsl_e0_busy", 32'(bus.busy), 32'h1);
        check("lsl_e0_out",  32'(bus.out),  32'hB3);
        check("lsl_e0_done", 32'(bus.done), 32'h0);
        step();
        check("lsl_e1_out",  32'(bus.out),  32'h66);
        check("lsl_e1_sout", 32'(bus.sout), 32'h1);
        step();
        check("lsl_e2_busy", 32'(bus.busy), 32'h1);
        check("lsl_e2_done", 32'(bus.done), 32'h0);
        step();
        check("lsl_e3_done", 32'(bus.done), 32'h1);
        check("lsl_e3_busy", 32'(bus.busy), 32'h0);
        check("lsl_e3_out",  32'(bus.out),  32'h98);
        check("lsl_e3_sout", 32'(bus.sout), 32'h1);
        step();
        check("lsl_hold_done", 32'(bus.done), 32'h0);
        check("lsl_hold_out",  32'(bus.out),  32'h98);

        // ASR 10000100 by 2
        issue(8'b1000_0100, 1'b1, 2'b01, 4'd2);
        step();
        check("asr_e1_out", 32'(bus.out), 32'hC2);
        step();
        check("asr_e2_done", 32'(bus.done), 32'h1);
        check("asr_e2_out",  32'(bus.out),  32'hE1);
        check("asr_e2_sout", 32'(bus.sout), 32'h0);
        step();

        // ROR 00000001 by 9 (amount beyond width)
        issue(8'b0000_0001, 1'b1, 2'b10, 4'd9);
        for (int i = 1; i < 9; i++) step();
        check("ror_e8_done", 32'(bus.done), 32'h0);
        check("ror_e8_out",  32'(bus.out),  32'h01);
        step();
        check("ror_e9_done", 32'(bus.done), 32'h1);
        check("ror_e9_out",  32'(bus.out),  32'h80);
        check("ror_e9_sout", 32'(bus.sout), 32'h1);
        step();

        // Serial-fill right, sin=1, by 4
        bus.sin = 1'b1;
        issue(8'h00, 1'b1, 2'b11, 4'd4);
        for (int i = 1; i <= 4; i++) step();
        check("sfr_done", 32'(bus.done), 32'h1);
        check("sfr_out",  32'(bus.out),  32'hF0);
        check("sfr_sout", 32'(bus.sout), 32'h0);
        bus.sin = 1'b0;
        step();

        // LSR of all-ones by 10: all zero
        issue(8'hFF, 1'b1, 2'b00, 4'd10);
        for (int i = 1; i <= 10; i++) step();
        check("lsr10_done", 32'(bus.done), 32'h1);
        check("lsr10_out",  32'(bus.out),  32'h00);
        step();

        // Stall for two cycles after edge 1, with a start attempted while busy
        issue(8'b1011_0011, 1'b0, 2'b00, 4'd3);
        step();
        check("stl_e1_out", 32'(bus.out), 32'h66);
        bus.en    = 1'b0;
        bus.start = 1'b1;
        bus.in    = 8'hFF;
        bus.amt   = 4'd1;
        step();
        check("stl_e2_out",  32'(bus.out),  32'h66);
        check("stl_e2_busy", 32'(bus.busy), 32'h1);
        check("stl_e2_done", 32'(bus.done), 32'h0);
        step();
        check("stl_e3_out",  32'(bus.out),  32'h66);
        check("stl_e3_done", 32'(bus.done), 32'h0);
        bus.en    = 1'b1;
        bus.start = 1'b0;
        step();
        check("stl_e4_out",  32'(bus.out),  32'hCC);
        check("stl_e4_done", 32'(bus.done), 32'h0);
        step();
        check("stl_e5_done", 32'(bus.done), 32'h1);
        check("stl_e5_out",  32'(bus.out),  32'h98);
        check("stl_e5_sout", 32'(bus.sout), 32'h1);
        step();

        // amt=0 completes on the accept edge, never busy
        issue(8'h5A, 1'b0, 2'b10, 4'd0);
        check("z_done", 32'(bus.done), 32'h1);
        check("z_busy", 32'(bus.busy), 32'h0);
        check("z_out",  32'(bus.out),  32'h5A);
        step();
        check("z_after_done", 32'(bus.done), 32'h0);

        // clr after edge 1 of an amt=5 op
        issue(8'h81, 1'b0, 2'b00, 4'd5);
        step();
        check("clr_e1_out", 32'(bus.out), 32'h02);
        bus.clr = 1'b1;
        step();
        check("clr_busy", 32'(bus.busy), 32'h0);
        check("clr_done", 32'(bus.done), 32'h0);
        check("clr_out",  32'(bus.out),  32'h02);
        check("clr_sout", 32'(bus.sout), 32'h1);
        // clr together with start while idle: start refused
        bus.start = 1'b1;
        bus.in    = 8'hA5;
        bus.amt   = 4'd0;
        step();
        check("clrst_out",  32'(bus.out),  32'h02);
        check("clrst_done", 32'(bus.done), 32'h0);
        bus.clr   = 1'b0;
        bus.start = 1'b0;
        step();
        check("clr_late_done", 32'(bus.done), 32'h0);

        // Asynchronous reset mid-operation
        issue(8'hFF, 1'b0, 2'b10, 4'd5);
        step();
        check("ar_pre_busy", 32'(bus.busy), 32'h1);
        #2 res = 1'b0;
        #1;
        check("ar_out",  32'(bus.out),  32'h00);
        check("ar_sout", 32'(bus.sout), 32'h0);
        check("ar_busy", 32'(bus.busy), 32'h0);
        check("ar_done", 32'(bus.done), 32'h0);
        @(negedge clk);
        res = 1'b1;
        step();
        check("ar_post_busy", 32'(bus.busy), 32'h0);
        check("ar_post_out",  32'(bus.out),  32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
